axi_cgra_cfg_slave: RTL and testbench

AXI4 slave that terminates the CGRA configuration window behind the crossbar (master port `ariane_soc::Accelerator`). It accepts single-beat and INCR-burst reads and writes from any crossbar initiator, holds a bank of 64-bit configuration registers, and turns a write of 1 to CTRL (offset 0x50) into a one-cycle start pulse for the CGRA datapath. It also reports busy/done status back to software.

---
 rtl/axi_cgra_cfg_slave_pkg.sv | 32 +++
 rtl/axi_cgra_cfg_slave_if.sv | 77 +++++++
 rtl/axi_cgra_cfg_slave.sv | 275 +++++++++++++++++++++++++++
 tb/tb_axi_cgra_cfg_slave.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_cgra_cfg_slave_pkg.sv
// cgra_cfg_pkg: register map, AXI codes and FSM states for axi_cgra_cfg_slave.
// No ports; provides CTRL/STATUS indices, bit positions and reg_idx().
package cgra_cfg_pkg;

   localparam int unsigned IDX_W = 9;
   typedef logic [IDX_W-1:0] idx_t;

   localparam idx_t CTRL_IDX   = 9'd10;
   localparam idx_t STATUS_IDX = 9'd11;

   localparam int unsigned CTRL_START_BIT = 0;
   localparam int unsigned STAT_BUSY_BIT  = 0;
   localparam int unsigned STAT_DONE_BIT  = 1;

   typedef logic [1:0] axi_burst_t;
   typedef logic [1:0] axi_resp_t;

   localparam axi_burst_t BURST_FIXED = 2'b00;
   localparam axi_burst_t BURST_INCR  = 2'b01;
   localparam axi_resp_t  RESP_OKAY   = 2'b00;
   localparam axi_resp_t  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wr_state_e;
   typedef enum logic       {RIDLE, RDATA}        rd_state_e;

   // Word index inside the 4 KiB window. Any value >= NUM_REGS
   // means a stray bit above the index field, i.e. out of range.
   function automatic idx_t reg_idx(input logic [11:0] off);
      return off[11:3];
   endfunction

endpackage

// File: rtl/axi_cgra_cfg_slave_if.sv
// AXI_BUS: AXI4 channel bundle (AW, W, B, AR, R) for the CGRA config slave.
// Modports: Master drives requests/ready for responses, Slave the reverse.
interface AXI_BUS
   import cgra_cfg_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 64,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 5,
   parameter int unsigned AXI_USER_WIDTH = 64
);

   logic [AXI_ID_WIDTH-1:0]     aw_id;
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]                  aw_len;
   logic [2:0]                  aw_size;
   axi_burst_t                  aw_burst;
   logic [AXI_USER_WIDTH-1:0]   aw_user;
   logic                        aw_valid;
   logic                        aw_ready;

   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_last;
   logic [AXI_USER_WIDTH-1:0]   w_user;
   logic                        w_valid;
   logic                        w_ready;

   logic [AXI_ID_WIDTH-1:0]     b_id;
   axi_resp_t                   b_resp;
   logic [AXI_USER_WIDTH-1:0]   b_user;
   logic                        b_valid;
   logic                        b_ready;

   logic [AXI_ID_WIDTH-1:0]     ar_id;
   logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]                  ar_len;
   logic [2:0]                  ar_size;
   axi_burst_t                  ar_burst;
   logic [AXI_USER_WIDTH-1:0]   ar_user;
   logic                        ar_valid;
   logic                        ar_ready;

   logic [AXI_ID_WIDTH-1:0]     r_id;
   logic [AXI_DATA_WIDTH-1:0]   r_data;
   axi_resp_t                   r_resp;
   logic                        r_last;
   logic [AXI_USER_WIDTH-1:0]   r_user;
   logic                        r_valid;
   logic                        r_ready;

   modport Master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport Slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );

endinterface

// File: rtl/axi_cgra_cfg_slave.sv
// axi_cgra_cfg_slave: AXI4 config window for the CGRA; 64-bit register bank,
// CTRL start pulse and busy/done STATUS.
// Ports: clk_i, rst_ni (async, active-low), slave (AXI_BUS.Slave),
// cfg_o (flat registers, reg i at [64i+:64]), start_o (pulse), done_i (pulse).
module axi_cgra_cfg_slave
   import cgra_cfg_pkg::*;
#(
   parameter int unsigned AXI_ID_WIDTH   = 5,
   parameter int unsigned AXI_ADDR_WIDTH = 64,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_USER_WIDTH = 64,
   parameter int unsigned NUM_REGS       = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   AXI_BUS.Slave                  slave,
   output logic [NUM_REGS*64-1:0] cfg_o,
   output logic                   start_o,
   input  logic                   done_i
);

   localparam idx_t NREGS = idx_t'(NUM_REGS);

   wr_state_e wr_state_q, wr_state_d;
   rd_state_e rd_state_q, rd_state_d;

   logic [63:0] regs_q [NUM_REGS];

   logic [AXI_ID_WIDTH-1:0]   aw_id_q;
   logic [11:0]               aw_addr_q;
   logic [7:0]                aw_len_q;
   axi_burst_t                aw_burst_q;
   logic [7:0]                wr_beat_q;
   logic                      wr_err_q;

   logic [AXI_ID_WIDTH-1:0]   ar_id_q;
   logic [11:0]               ar_addr_q;
   logic [7:0]                ar_len_q;
   axi_burst_t                ar_burst_q;
   logic [7:0]                rd_beat_q;
   logic [AXI_DATA_WIDTH-1:0] r_data_q;
   axi_resp_t                 r_resp_q;
   logic                      r_last_q;

   logic start_q, busy_q, done_q;

   logic aw_hs, w_hs, ar_hs, r_hs;
   assign aw_hs = slave.aw_valid & slave.aw_ready;
   assign w_hs  = slave.w_valid  & slave.w_ready;
   assign ar_hs = slave.ar_valid & slave.ar_ready;
   assign r_hs  = slave.r_valid  & slave.r_ready;

   // ---------------- write beat decode ----------------
   logic [11:0] wr_off;
   idx_t        wr_idx;
   logic        wr_bad, wr_en, wr_last_err, start_evt;

   always_comb begin
      wr_off = aw_addr_q;
      if (aw_burst_q != BURST_FIXED)
         wr_off = aw_addr_q + {1'b0, wr_beat_q, 3'b000};
      wr_idx = reg_idx(wr_off);
      // Unsupported burst, out of range or read-only: drop the beat.
      wr_bad = (aw_burst_q != BURST_FIXED && aw_burst_q != BURST_INCR)
             || wr_idx >= NREGS
             || wr_idx == STATUS_IDX;
      wr_en = w_hs & ~wr_bad & (wr_idx != CTRL_IDX);
      start_evt = w_hs & ~wr_bad & (wr_idx == CTRL_IDX)
                & slave.w_strb[CTRL_START_BIT]
                & slave.w_data[CTRL_START_BIT];
      wr_last_err = slave.w_last != (wr_beat_q == aw_len_q);
   end

   // ---------------- write FSM ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) wr_state_q <= WIDLE;
      else         wr_state_q <= wr_state_d;
   end

   always_comb begin
      wr_state_d     = wr_state_q;
      slave.aw_ready = 1'b0;
      slave.w_ready  = 1'b0;
      slave.b_valid  = 1'b0;
      unique case (wr_state_q)
         WIDLE: begin
            slave.aw_ready = 1'b1;
            if (slave.aw_valid) wr_state_d = WDATA;
         end
         WDATA: begin
            slave.w_ready = 1'b1;
            if (slave.w_valid && slave.w_last) wr_state_d = WRESP;
         end
         WRESP: begin
            slave.b_valid = 1'b1;
            if (slave.b_ready) wr_state_d = WIDLE;
         end
         default: wr_state_d = WIDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         aw_id_q    <= '0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_burst_q <= BURST_FIXED;
         wr_beat_q  <= '0;
         wr_err_q   <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_id_q    <= slave.aw_id;
            aw_addr_q  <= slave.aw_addr[11:0];
            aw_len_q   <= slave.aw_len;
            aw_burst_q <= slave.aw_burst;
            wr_beat_q  <= '0;
            wr_err_q   <= 1'b0;
         end
         if (w_hs) begin
            wr_beat_q <= wr_beat_q + 8'd1;
            if (wr_bad || wr_last_err) wr_err_q <= 1'b1;
         end
      end
   end

   assign slave.b_id   = aw_id_q;
   assign slave.b_resp = wr_err_q ? RESP_SLVERR : RESP_OKAY;
   assign slave.b_user = {AXI_USER_WIDTH{1'b0}};

   // ---------------- register bank ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == idx_t'(i)) begin
               for (int b = 0; b < 8; b++) begin
                  if (slave.w_strb[b])
                     regs_q[i][8*b +: 8] <= slave.w_data[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      cfg_o = '0;
      for (int i = 0; i < NUM_REGS; i++) cfg_o[64*i +: 64] = regs_q[i];
   end

   // ---------------- control / status ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         start_q <= start_evt;
         // A start in the same cycle as done takes priority.
         if (start_evt) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
         end else if (done_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   assign start_o = start_q;

   // ---------------- read beat decode ----------------
   // In RIDLE this looks up beat 0 of the incoming AR; in RDATA the
   // beat after the one on the bus, so r_data is loaded a cycle early.
   logic [11:0] rd_base, rd_off;
   axi_burst_t  rd_burst;
   logic [7:0]  rd_len, rd_nbeat;
   idx_t        rd_idx;
   logic [63:0] rd_word;
   logic        rd_err;

   always_comb begin
      rd_base  = ar_addr_q;
      rd_burst = ar_burst_q;
      rd_len   = ar_len_q;
      rd_nbeat = rd_beat_q + 8'd1;
      if (rd_state_q == RIDLE) begin
         rd_base  = slave.ar_addr[11:0];
         rd_burst = slave.ar_burst;
         rd_len   = slave.ar_len;
         rd_nbeat = '0;
      end
      rd_off = rd_base;
      if (rd_burst != BURST_FIXED)
         rd_off = rd_base + {1'b0, rd_nbeat, 3'b000};
      rd_idx  = reg_idx(rd_off);
      rd_word = '0;
      rd_err  = 1'b0;
      if ((rd_burst != BURST_FIXED && rd_burst != BURST_INCR)
          || rd_idx >= NREGS) begin
         rd_err = 1'b1;
      end else if (rd_idx == STATUS_IDX) begin
         rd_word[STAT_BUSY_BIT] = busy_q;
         rd_word[STAT_DONE_BIT] = done_q;
      end else if (rd_idx != CTRL_IDX) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == idx_t'(i)) rd_word = regs_q[i];
         end
      end
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_state_q <= RIDLE;
      else         rd_state_q <= rd_state_d;
   end

   always_comb begin
      rd_state_d     = rd_state_q;
      slave.ar_ready = 1'b0;
      slave.r_valid  = 1'b0;
      unique case (rd_state_q)
         RIDLE: begin
            slave.ar_ready = 1'b1;
            if (slave.ar_valid) rd_state_d = RDATA;
         end
         RDATA: begin
            slave.r_valid = 1'b1;
            if (slave.r_ready && r_last_q) rd_state_d = RIDLE;
         end
         default: rd_state_d = RIDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_burst_q <= BURST_FIXED;
         rd_beat_q  <= '0;
         r_data_q   <= '0;
         r_resp_q   <= RESP_OKAY;
         r_last_q   <= 1'b0;
      end else begin
         if (ar_hs) begin
            ar_id_q    <= slave.ar_id;
            ar_addr_q  <= slave.ar_addr[11:0];
            ar_len_q   <= slave.ar_len;
            ar_burst_q <= slave.ar_burst;
            rd_beat_q  <= '0;
         end
         if (ar_hs || (r_hs && !r_last_q)) begin
            r_data_q <= rd_word;
            r_resp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            r_last_q <= (rd_nbeat == rd_len);
            if (r_hs) rd_beat_q <= rd_nbeat;
         end
      end
   end

   assign slave.r_id   = ar_id_q;
   assign slave.r_data = r_data_q;
   assign slave.r_resp = r_resp_q;
   assign slave.r_last = r_last_q;
   assign slave.r_user = {AXI_USER_WIDTH{1'b0}};

   // Fields this window never looks at.
   logic unused_ok;
   assign unused_ok = ^{slave.aw_addr[AXI_ADDR_WIDTH-1:12],
                        slave.ar_addr[AXI_ADDR_WIDTH-1:12],
                        slave.aw_size, slave.ar_size,
                        slave.aw_user, slave.w_user, slave.ar_user};

endmodule

// File: tb/tb_axi_cgra_cfg_slave.sv
// tb_axi_cgra_cfg_slave: directed bench for axi_cgra_cfg_slave with
// register/status model and B/R scoreboard queues.
module tb_axi_cgra_cfg_slave;
   import cgra_cfg_pkg::*;

   localparam int NR = 16;
   localparam logic [1:0] BURST_WRAP = 2'b10;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start;
   logic             done_in = 1'b0;
   logic [NR*64-1:0] cfg;

   AXI_BUS #(
      .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
      .AXI_ID_WIDTH(5), .AXI_USER_WIDTH(64)
   ) bus ();

   axi_cgra_cfg_slave #(
      .AXI_ID_WIDTH(5), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
      .AXI_USER_WIDTH(64), .NUM_REGS(NR)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .slave(bus),
      .cfg_o(cfg), .start_o(start), .done_i(done_in)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] id;
      logic [1:0] resp;
   } b_exp_t;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [4:0]  id;
   } r_exp_t;

   b_exp_t exp_b[$];
   r_exp_t exp_r[$];

   int errors = 0;
   int checks = 0;
   int start_cnt = 0;

   logic [63:0] mdl [NR];
   logic        st_busy, st_done;
   logic [63:0] wdat [8];

   always @(negedge clk) if (start) start_cnt++;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic expire(input string tag);
      checks++;
      assert (1'b0) else begin
         errors++;
         $error("FAIL %s: got timeout want response", tag);
      end
   endtask

   task automatic check_cfg(input string tag);
      for (int i = 0; i < NR; i++) check(tag, cfg[64*i +: 64], mdl[i]);
   endtask

   function automatic logic [11:0] beat_off(input logic [11:0] off,
                                             input logic [1:0] burst,
                                             input int b);
      return (burst == BURST_FIXED) ? off : off + 12'(8 * b);
   endfunction

   function automatic bit off_bad(input logic [11:0] off,
                                  input logic [1:0] burst, input bit wr);
      logic [8:0] idx;
      idx = off[11:3];
      return burst[1] || idx >= 9'd16 || (wr && idx == 9'd11);
   endfunction

   task automatic wr_burst(input logic [4:0] id, input logic [11:0] off,
                           input logic [7:0] len, input logic [1:0] burst,
                           input int nb, input logic [7:0] strb);
      logic        err;
      logic [11:0] o;
      int          b, cyc;
      bit          awf, wf;
      err = 1'b0;
      for (int k = 0; k < nb; k++) begin
         o = beat_off(off, burst, k);
         if (off_bad(o, burst, 1'b1)) begin
            err = 1'b1;
         end else if (o[11:3] == 9'd10) begin
            if (strb[0] && wdat[k][0]) begin
               st_busy = 1'b1;
               st_done = 1'b0;
            end
         end else begin
            for (int j = 0; j < 8; j++)
               if (strb[j]) mdl[o[6:3]][8*j +: 8] = wdat[k][8*j +: 8];
         end
         if ((k == nb - 1) != (k == int'(len))) err = 1'b1;
      end
      exp_b.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
      @(negedge clk);
      bus.aw_valid = 1'b1;
      bus.aw_id    = id;
      bus.aw_addr  = 64'h5000_0000 | 64'(off);
      bus.aw_len   = len;
      bus.aw_size  = 3'd3;
      bus.aw_burst = burst;
      bus.w_valid  = 1'b1;
      bus.w_data   = wdat[0];
      bus.w_strb   = strb;
      bus.w_last   = (nb == 1);
      b = 0;
      cyc = 0;
      while ((bus.aw_valid || bus.w_valid) && cyc < 100) begin
         awf = bus.aw_valid && bus.aw_ready;
         wf  = bus.w_valid && bus.w_ready;
         @(negedge clk);
         cyc++;
         if (awf) bus.aw_valid = 1'b0;
         if (wf) begin
            b++;
            if (b < nb) begin
               bus.w_data = wdat[b];
               bus.w_last = (b == nb - 1);
            end else begin
               bus.w_valid = 1'b0;
            end
         end
      end
      if (cyc >= 100) expire("wr_accept");
      bus.aw_valid = 1'b0;
      bus.w_valid  = 1'b0;
   endtask

   task automatic wait_b();
      b_exp_t e;
      int     cyc;
      cyc = 0;
      bus.b_ready = 1'b1;
      while (!bus.b_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      e = exp_b.pop_front();
      if (!bus.b_valid) begin
         expire("b_valid");
      end else begin
         check("b_id", 64'(bus.b_id), 64'(e.id));
         check("b_resp", 64'(bus.b_resp), 64'(e.resp));
      end
      @(negedge clk);
      bus.b_ready = 1'b0;
   endtask

   task automatic rd_burst(input logic [4:0] id, input logic [11:0] off,
                           input logic [7:0] len, input logic [1:0] burst,
                           input int stall_at);
      int          nb, got, cyc;
      bit          stalled;
      r_exp_t      e;
      logic [11:0] o;
      logic [63:0] d;
      logic [1:0]  rs;
      nb = int'(len) + 1;
      stalled = 1'b0;
      for (int k = 0; k < nb; k++) begin
         o  = beat_off(off, burst, k);
         d  = '0;
         rs = 2'b00;
         if (off_bad(o, burst, 1'b0)) rs = 2'b10;
         else if (o[11:3] == 9'd11) d = {62'b0, st_done, st_busy};
         else if (o[11:3] != 9'd10) d = mdl[o[6:3]];
         exp_r.push_back('{data: d, resp: rs, last: (k == nb - 1), id: id});
      end
      @(negedge clk);
      bus.ar_valid = 1'b1;
      bus.ar_id    = id;
      bus.ar_addr  = 64'h5000_0000 | 64'(off);
      bus.ar_len   = len;
      bus.ar_size  = 3'd3;
      bus.ar_burst = burst;
      cyc = 0;
      while (!bus.ar_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      bus.ar_valid = 1'b0;
      bus.r_ready  = 1'b1;
      got = 0;
      cyc = 0;
      while (got < nb && cyc < 200) begin
         if (bus.r_valid) begin
            if (got == stall_at && !stalled) begin
               stalled = 1'b1;
               bus.r_ready = 1'b0;
               for (int k = 0; k < 3; k++) begin
                  @(negedge clk);
                  check("r_hold_valid", 64'(bus.r_valid), 64'd1);
                  check("r_hold_data", bus.r_data, exp_r[0].data);
               end
               bus.r_ready = 1'b1;
            end
            e = exp_r.pop_front();
            check("r_data", bus.r_data, e.data);
            check("r_resp", 64'(bus.r_resp), 64'(e.resp));
            check("r_last", 64'(bus.r_last), 64'(e.last));
            check("r_id", 64'(bus.r_id), 64'(e.id));
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      bus.r_ready = 1'b0;
      if (got < nb) begin
         expire("r_beats");
         exp_r.delete();
      end
   endtask

   initial begin
      bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_addr = '0;
      bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
      bus.aw_user = '0;
      bus.w_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0;
      bus.w_last = 1'b0; bus.w_user = '0;
      bus.b_ready = 1'b0;
      bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_addr = '0;
      bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
      bus.ar_user = '0;
      bus.r_ready = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      st_busy = 1'b0;
      st_done = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_b_valid", 64'(bus.b_valid), 64'd0);
      check("rst_r_valid", 64'(bus.r_valid), 64'd0);
      check("rst_start", 64'(start), 64'd0);
      check_cfg("rst_cfg");
      rst_n = 1'b1;
      @(negedge clk);
      check("aw_ready", 64'(bus.aw_ready), 64'd1);
      check("ar_ready", 64'(bus.ar_ready), 64'd1);
      check("w_ready_idle", 64'(bus.w_ready), 64'd0);

      // CTRL start, then done
      start_cnt = 0;
      wdat[0] = 64'h1;
      wr_burst(5'h03, 12'h050, 8'd0, BURST_INCR, 1, 8'hFF);
      wait_b();
      check("start_once", 64'(start_cnt), 64'd1);
      check("start_low", 64'(start), 64'd0);
      rd_burst(5'h11, 12'h058, 8'd0, BURST_INCR, -1);
      @(negedge clk);
      done_in = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      st_busy = 1'b0;
      st_done = 1'b1;
      rd_burst(5'h12, 12'h058, 8'd0, BURST_INCR, -1);
      rd_burst(5'h13, 12'h050, 8'd0, BURST_INCR, -1);

      // partial strobe write
      wdat[0] = 64'hDEAD_BEEF_0123_4567;
      wr_burst(5'h01, 12'h018, 8'd0, BURST_INCR, 1, 8'h0F);
      wait_b();
      check_cfg("strb_cfg");
      rd_burst(5'h02, 12'h018, 8'd0, BURST_INCR, -1);

      // INCR burst write/read with stall
      for (int k = 0; k < 4; k++) wdat[k] = 64'(k + 1);
      wr_burst(5'h04, 12'h020, 8'd3, BURST_INCR, 4, 8'hFF);
      wait_b();
      check_cfg("incr_cfg");
      rd_burst(5'h05, 12'h020, 8'd3, BURST_INCR, 1);

      // STATUS and out-of-range writes/read
      wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      wr_burst(5'h06, 12'h058, 8'd0, BURST_INCR, 1, 8'hFF);
      wait_b();
      wr_burst(5'h07, 12'h0A0, 8'd0, BURST_INCR, 1, 8'hFF);
      wait_b();
      check_cfg("oor_cfg");
      rd_burst(5'h08, 12'h0A0, 8'd0, BURST_INCR, -1);

      // early w_last, then a clean write
      wdat[0] = 64'h55;
      wr_burst(5'h09, 12'h060, 8'd1, BURST_INCR, 1, 8'hFF);
      wait_b();
      wdat[0] = 64'h66;
      wr_burst(5'h0A, 12'h068, 8'd0, BURST_INCR, 1, 8'hFF);
      wait_b();
      check_cfg("last_cfg");

      // FIXED burst lands on one register; WRAP is rejected
      wdat[0] = 64'hA;
      wdat[1] = 64'hB;
      wr_burst(5'h0B, 12'h070, 8'd1, BURST_FIXED, 2, 8'hFF);
      wait_b();
      wr_burst(5'h0C, 12'h078, 8'd1, BURST_WRAP, 2, 8'hFF);
      wait_b();
      check_cfg("fixed_wrap_cfg");
      rd_burst(5'h0D, 12'h070, 8'd1, BURST_FIXED, -1);

      // reset in the middle of a write
      @(negedge clk);
      bus.aw_valid = 1'b1;
      bus.aw_id    = 5'h0E;
      bus.aw_addr  = 64'h5000_0008;
      bus.aw_len   = 8'd0;
      bus.aw_burst = BURST_INCR;
      @(negedge clk);
      bus.aw_valid = 1'b0;
      check("mid_w_ready", 64'(bus.w_ready), 64'd1);
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      st_busy = 1'b0;
      st_done = 1'b0;
      start_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_mid_b_valid", 64'(bus.b_valid), 64'd0);
      end
      check_cfg("rst_mid_cfg");
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_b_valid2", 64'(bus.b_valid), 64'd0);
      wdat[0] = 64'h1234;
      wr_burst(5'h0F, 12'h008, 8'd0, BURST_INCR, 1, 8'hFF);
      wait_b();
      check_cfg("post_rst_cfg");
      rd_burst(5'h10, 12'h058, 8'd0, BURST_INCR, -1);
      check("no_start_after_rst", 64'(start_cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
